// File: rtl/apb_master.sv
// APB3 requester: turns valid/ready read/write commands into SETUP/ACCESS
// transfers and returns one registered response per transfer, with a wait-state timeout.
module apb_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // A zero TIMEOUT would give a zero-width counter, so keep at least one bit.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              timeout_hit;
  logic              accept;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cmd_ready     = 1'b0;
    timeout_hit   = (TIMEOUT != 0) && !pready && (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          cmd_ready     = 1'b1;
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          cmd_ready     = 1'b1;
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A command taken at the end of ACCESS skips IDLE so psel stays high.
    accept = cmd_valid && cmd_ready;
    if (accept) begin
      state_d  = SETUP;
      cnt_d    = '0;
      pwrite_d = cmd_write;
      paddr_d  = cmd_addr;
      pwdata_d = cmd_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign psel        = (state_q != IDLE);
  assign penable     = (state_q == ACCESS);
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed plan cases plus random transfers
// checked against a per-transfer model of latency and response contents.
module tb_apb_master;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int TO     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_err, rsp_timeout;
  logic [DATA_W-1:0] rsp_rdata;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata, prdata;
  logic              pready, pslverr;

  int checks = 0;
  int errors = 0;

  apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkBusIdle(input string tag);
    checkOutput({tag, " psel"}, 32'(psel), 32'd0);
    checkOutput({tag, " penable"}, 32'(penable), 32'd0);
  endtask

  // One transfer from an idle bus. nwait = low-pready ACCESS cycles before ready.
  task automatic applyStimulus(input bit wr, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wd, input int nwait,
                               input bit serr, input logic [DATA_W-1:0] rd);
    bit                to;
    int                nacc;
    logic [DATA_W-1:0] exp_rd;
    bit                exp_err;
    to      = (TO != 0) && (nwait >= TO);
    nacc    = to ? TO : nwait + 1;
    exp_err = to ? 1'b1 : serr;
    exp_rd  = (to || wr) ? '0 : rd;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    pready = 1'($urandom); pslverr = 1'($urandom);
    #1;
    checkOutput("idle cmd_ready", 32'(cmd_ready), 32'd1);
    checkBusIdle("idle");

    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom);
    cmd_addr = ADDR_W'($urandom); cmd_wdata = $urandom;
    pready = 1'($urandom); pslverr = 1'b1; prdata = $urandom;
    #1;
    checkOutput("setup psel", 32'(psel), 32'd1);
    checkOutput("setup penable", 32'(penable), 32'd0);
    checkOutput("setup cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("setup paddr", 32'(paddr), 32'(addr));
    checkOutput("setup pwdata", pwdata, wd);
    checkOutput("setup pwrite", 32'(pwrite), 32'(wr));
    checkOutput("setup rsp_valid", 32'(rsp_valid), 32'd0);

    for (int i = 0; i < nacc; i++) begin
      @(negedge clk);
      pready  = (i == nwait);
      pslverr = (i == nwait) ? serr : 1'($urandom);
      prdata  = (i == nwait) ? rd : $urandom;
      #1;
      checkOutput("access psel", 32'(psel), 32'd1);
      checkOutput("access penable", 32'(penable), 32'd1);
      checkOutput("access paddr", 32'(paddr), 32'(addr));
      checkOutput("access rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("access cmd_ready", 32'(cmd_ready), 32'((i == nwait) || (to && i == nacc - 1)));
    end

    @(negedge clk);
    pready = 1'b1; pslverr = 1'($urandom); prdata = $urandom;
    #1;
    checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("rsp_rdata", rsp_rdata, exp_rd);
    checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
    checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(to));
    checkBusIdle("rsp");

    @(negedge clk);
    pready = 1'($urandom); pslverr = 1'($urandom);
    #1;
    checkOutput("rsp pulse end", 32'(rsp_valid), 32'd0);
    checkBusIdle("after rsp");
  endtask

  // Three zero-wait commands with cmd_valid held throughout.
  task automatic backToBack();
    logic              wr [3];
    logic [ADDR_W-1:0] ad [3];
    logic [DATA_W-1:0] wd [3];
    logic [DATA_W-1:0] rd [3];
    for (int j = 0; j < 3; j++) begin
      wr[j] = 1'($urandom); ad[j] = ADDR_W'($urandom);
      wd[j] = $urandom; rd[j] = $urandom;
    end
    cmd_valid = 1'b1; cmd_write = wr[0]; cmd_addr = ad[0]; cmd_wdata = wd[0];
    pready = 1'b1; pslverr = 1'b0;
    #1;
    checkOutput("b2b cmd_ready", 32'(cmd_ready), 32'd1);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (j < 2) begin
        cmd_write = wr[j+1]; cmd_addr = ad[j+1]; cmd_wdata = wd[j+1];
      end else begin
        cmd_valid = 1'b0;
      end
      prdata = rd[j];
      #1;
      checkOutput("b2b setup psel", 32'(psel), 32'd1);
      checkOutput("b2b setup penable", 32'(penable), 32'd0);
      checkOutput("b2b paddr", 32'(paddr), 32'(ad[j]));
      checkOutput("b2b pwdata", pwdata, wd[j]);
      checkOutput("b2b rsp_valid", 32'(rsp_valid), 32'(j > 0));
      if (j > 0)
        checkOutput("b2b rsp_rdata", rsp_rdata, wr[j-1] ? 32'd0 : rd[j-1]);
      @(negedge clk);
      #1;
      checkOutput("b2b access psel", 32'(psel), 32'd1);
      checkOutput("b2b access penable", 32'(penable), 32'd1);
      checkOutput("b2b access rsp_valid", 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    #1;
    checkOutput("b2b last rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("b2b last rsp_rdata", rsp_rdata, wr[2] ? 32'd0 : rd[2]);
    checkBusIdle("b2b end");
    @(negedge clk);
    #1;
    checkOutput("b2b pulse end", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkBusIdle("reset");
    checkOutput("reset paddr", 32'(paddr), 32'd0);
    checkOutput("reset pwdata", pwdata, 32'd0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset rsp_err", {30'd0, rsp_err, rsp_timeout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed transfers");
    applyStimulus(1'b1, 12'h004, 32'hA5A5_0001, 0, 1'b0, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 12'h008, 32'h0, 3, 1'b0, 32'h0000_1234);
    applyStimulus(1'b0, 12'h00C, 32'h0, 0, 1'b1, 32'h5555_AAAA);
    applyStimulus(1'b0, 12'h010, 32'h0, TO + 2, 1'b0, 32'h1111_2222);
    applyStimulus(1'b1, 12'hFFC, 32'hFFFF_FFFF, TO - 1, 1'b0, 32'h0);
    backToBack();

    $display("[TB] reset during ACCESS");
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h0AB; pready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2;
    checkOutput("pre-reset penable", 32'(penable), 32'd1);
    rst = 1'b1;
    #1;
    checkBusIdle("async reset");
    checkOutput("async reset paddr", 32'(paddr), 32'd0);
    @(negedge clk);
    pready = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("post-reset rsp_valid", 32'(rsp_valid), 32'd0);
    end
    applyStimulus(1'b0, 12'h0AB, 32'h0, 1, 1'b0, 32'hCAFE_F00D);

    $display("[TB] random transfers");
    for (int n = 0; n < 30; n++)
      applyStimulus(1'($urandom), ADDR_W'($urandom), $urandom,
                    int'($urandom_range(0, TO + 2)), 1'($urandom), $urandom);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

APB3 requester that turns single-word read/write commands into compliant SETUP/ACCESS bus transfers toward the timer register block. Commands use a valid/ready handshake. Each transfer returns one registered response carrying read data, the slave error and a wait-state timeout flag. A programmable timeout guarantees the bus cannot hang on a completer that never asserts pready.

## Interface
- ADDR_W, 12, width of cmd_addr and paddr
- DATA_W, 32, width of write/read data
- TIMEOUT, 16, maximum ACCESS cycles with pready low before abort; 0 disables the timeout
- clk  input  1  single clock, all logic rising-edge
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted this cycle when cmd_valid & cmd_ready
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_W  transfer address
- cmd_wdata  input  DATA_W  write data, ignored for reads
- rsp_valid  output  1  one-cycle pulse, response fields valid
- rsp_rdata  output  DATA_W  read data; 0 for writes and for timeouts
- rsp_err  output  1  pslverr of completed transfer, or 1 on timeout
- rsp_timeout  output  1  transfer aborted by timeout
- psel, penable, pwrite  output  1  APB control
- paddr  output  ADDR_W  APB address
- pwdata  output  DATA_W  APB write data
- prdata  input  DATA_W  APB read data
- pready  input  1  completer ready
- pslverr  input  1  completer error

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: psel=0, penable=0, cmd_ready=1.
  - On cmd_valid, latch cmd_write/addr/wdata into pwrite/paddr/pwdata and go to SETUP.
- SETUP: psel=1, penable=0, cmd_ready=0. Always go to ACCESS next cycle.
- ACCESS: psel=1, penable=1. The wait counter increments each cycle pready=0.
  - pready=1: transfer completes. Capture prdata (reads only) and pslverr into the response registers.
  - pready=0 and counter reaches TIMEOUT (TIMEOUT≠0): abort. Response is rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - On completion or abort, cmd_ready=1 combinationally in that cycle.
    - If cmd_valid is high, the new command is latched and the FSM goes directly to SETUP. psel stays 1; penable drops to 0.
    - Otherwise the FSM goes to IDLE.
  - Otherwise the FSM stays in ACCESS with cmd_ready=0.
- pwrite/paddr/pwdata change only on command acceptance. They hold their last values in IDLE.
- Wait counter is $clog2(TIMEOUT+1) bits. It clears on entry to SETUP.
- Aborted transfers drop psel regardless of pready. A late pready after abort is ignored.

## Timing
- Reset (asynchronous, immediate) forces:
  - state IDLE, counter 0
  - psel, penable, pwrite = 0; paddr, pwdata = 0
  - rsp_valid, rsp_err, rsp_timeout = 0; rsp_rdata = 0
- Reset mid-transfer abandons the transfer and produces no response.
- Command accepted at edge T: SETUP in cycle T+1, ACCESS from T+2.
- Zero wait states: pready=1 in the T+2 cycle gives rsp_valid=1 in cycle T+3, exactly one cycle.
- Each low-pready cycle adds one cycle of latency.
- Back-to-back commands: psel stays high continuously, with SETUP immediately after the completing ACCESS. Throughput is 2 cycles per zero-wait transfer.
- With TIMEOUT=N, pready held low: abort at the end of the Nth ACCESS cycle. rsp_valid follows one cycle later, and psel=0 in the same cycle if there is no queued command.
- rsp_valid is never held; there is no response backpressure.
- pslverr and prdata are sampled only when penable & pready.

## Test plan
- Zero-wait write: cmd addr=0x004, wdata=0xA5A5_0001, pready tied 1.
  - Required: psel=1/penable=0 one cycle, then psel=penable=1 one cycle, paddr=0x004, pwdata=0xA5A5_0001.
  - Then rsp_valid pulse with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: prdata=0x0000_1234, pready low 3 ACCESS cycles then high.
  - Required: ACCESS lasts 4 cycles, rsp_rdata=0x0000_1234, rsp_valid 6 cycles after acceptance.
- Slave error: read with pready=1, pslverr=1.
  - Required: rsp_err=1, rsp_timeout=0.
  - pslverr asserted outside ACCESS must be ignored.
- Timeout: TIMEOUT=4, pready held 0.
  - Required: exactly 4 ACCESS cycles, then psel=0 and rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - pready=1 one cycle later causes no second response.
- Back-to-back: three commands with cmd_valid held, pready=1.
  - Required: psel high continuously for 6 cycles, penable pattern 0,1,0,1,0,1, three rsp_valid pulses two cycles apart.
- Reset in ACCESS: assert rst while pready=0.
  - Required: psel/penable/paddr clear without waiting for a clock edge, no rsp_valid.
  - Next command after release behaves as from IDLE.
